// File: rtl/game_pkg.sv
// Shared types and constants for the ping-pong button conditioner.
// Defaults assume the 25 MHz pixel clock.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } rpt_state_t;

  localparam int unsigned PIXEL_CLK_HZ        = 25_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = PIXEL_CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = PIXEL_CLK_HZ / 2;    // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = PIXEL_CLK_HZ / 10;   // 100 ms

  // Bits needed to hold max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    cnt_width = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/paddle_input_cond_if.sv
// Button-side bundle: raw buttons and repeat enables in, conditioned strobes out.
interface paddle_input_cond_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] btn_i;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] move_o;

  modport master (
    output btn_i, repeat_en,
    input  level_o, press_o, release_o, move_o
  );

  modport slave (
    input  btn_i, repeat_en,
    output level_o, press_o, release_o, move_o
  );
endinterface

// File: rtl/input_cond_ch.sv
// One button channel: synchroniser, debounce, edge strobes and repeat FSM.
//   state     | meaning
//   ST_IDLE   | button released, waiting for a debounced press
//   ST_ARM    | pressed, counting down the initial repeat delay
//   ST_REPEAT | auto-repeating every repeat period
//   ST_HELD   | pressed with repeat disabled, waiting for release
module input_cond_ch
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic pixel_clk,
  input  logic reset,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_move_raw
);

  localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned RPT_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_move;
  logic [RPT_W-1:0]       r_rpt_cnt;
  rpt_state_t             r_state;

  logic w_s;
  logic w_diff;
  logic w_flip;
  logic w_rise;
  logic w_fall;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_level;
  assign w_flip = w_diff && (r_db_cnt == DB_LAST);
  assign w_rise = w_flip & ~r_level;
  assign w_fall = w_flip &  r_level;

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '0;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_db_cnt  <= (!w_diff || w_flip) ? '0 : r_db_cnt + DB_W'(1);
      r_level   <= r_level ^ w_flip;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // Release is checked first in every pressed state so a due repeat is dropped.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_rpt_cnt <= '0;
      r_move    <= 1'b0;
    end else begin
      r_move <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state   <= ST_ARM;
            r_move    <= 1'b1;
            r_rpt_cnt <= DELAY_LD;
          end
        end
        ST_ARM: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
          end else if (!i_repeat_en) begin
            r_state <= ST_HELD;
          end else if (r_rpt_cnt == '0) begin
            r_state   <= ST_REPEAT;
            r_move    <= 1'b1;
            r_rpt_cnt <= PERIOD_LD;
          end else begin
            r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
          end else if (!i_repeat_en) begin
            r_state <= ST_HELD;
          end else if (r_rpt_cnt == '0) begin
            r_move    <= 1'b1;
            r_rpt_cnt <= PERIOD_LD;
          end else begin
            r_rpt_cnt <= r_rpt_cnt - RPT_W'(1);
          end
        end
        ST_HELD: begin
          if (w_fall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_level    = r_level;
  assign o_press    = r_press;
  assign o_release  = r_release;
  assign o_move_raw = r_move;

endmodule

// File: rtl/paddle_input_cond.sv
// N-channel paddle button conditioner with optional up/down pair lockout.
// All outputs pass through one common output register.
module paddle_input_cond
  import game_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned PAIR_LOCKOUT    = 1
) (
  input  logic                pixel_clk,
  input  logic                reset,
  paddle_input_cond_if.slave  io_bus
);

  if (SYNC_STAGES < 2)      begin : g_chk_sync   $error("SYNC_STAGES must be at least 2");     end
  if (DEBOUNCE_CYCLES < 1)  begin : g_chk_db     $error("DEBOUNCE_CYCLES must be at least 1"); end
  if (REPEAT_DELAY < 1)     begin : g_chk_delay  $error("REPEAT_DELAY must be at least 1");    end
  if (REPEAT_PERIOD < 1)    begin : g_chk_period $error("REPEAT_PERIOD must be at least 1");   end
  if (N_CH < 1)             begin : g_chk_nch    $error("N_CH must be at least 1");            end
  if ((PAIR_LOCKOUT != 0) && (N_CH % 2 != 0)) begin : g_chk_pair
    $error("PAIR_LOCKOUT requires an even N_CH");
  end

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_release;
  logic [N_CH-1:0] w_move_raw;
  logic [N_CH-1:0] w_lock;
  logic [N_CH-1:0] w_move;

  logic [N_CH-1:0] r_level;
  logic [N_CH-1:0] r_press;
  logic [N_CH-1:0] r_release;
  logic [N_CH-1:0] r_move;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .i_btn       (io_bus.btn_i[c]),
      .i_repeat_en (io_bus.repeat_en[c]),
      .o_level     (w_level[c]),
      .o_press     (w_press[c]),
      .o_release   (w_release[c]),
      .o_move_raw  (w_move_raw[c])
    );
  end

  // Both buttons of a pair held means conflicting input: mute the pair's moves.
  always_comb begin
    w_lock = '0;
    if (PAIR_LOCKOUT != 0) begin
      for (int k = 0; k < int'(N_CH / 2); k++) begin
        w_lock[2*k]   = w_level[2*k] & w_level[2*k+1];
        w_lock[2*k+1] = w_level[2*k] & w_level[2*k+1];
      end
    end
  end

  assign w_move = w_move_raw & ~w_lock;

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_move    <= '0;
    end else begin
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
      r_move    <= w_move;
    end
  end

  assign io_bus.level_o   = r_level;
  assign io_bus.press_o   = r_press;
  assign io_bus.release_o = r_release;
  assign io_bus.move_o    = r_move;

endmodule

// File: tb/tb_paddle_input_cond.sv
// Directed bench for paddle_input_cond with short debounce/repeat constants.
// Edge e of a scenario is the first posedge that captures the new button value.
module tb_paddle_input_cond;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  paddle_input_cond_if #(.N_CH(4)) bus ();

  paddle_input_cond #(
    .N_CH            (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3),
    .PAIR_LOCKOUT    (1)
  ) dut (
    .pixel_clk (clk),
    .reset     (rst_n),
    .io_bus    (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    bus.btn_i     = '0;
    bus.repeat_en = '0;
    repeat (15) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_i = '0;
    bus.repeat_en = '0;
    repeat (3) tick();
    n_chk++; if (bus.level_o !== 4'h0) $display("FAIL reset_level: got %b want 0000", bus.level_o); else n_pass++;
    n_chk++; if (bus.press_o !== 4'h0) $display("FAIL reset_press: got %b want 0000", bus.press_o); else n_pass++;
    n_chk++; if (bus.release_o !== 4'h0) $display("FAIL reset_release: got %b want 0000", bus.release_o); else n_pass++;
    n_chk++; if (bus.move_o !== 4'h0) $display("FAIL reset_move: got %b want 0000", bus.move_o); else n_pass++;
    rst_n = 1'b1;
    repeat (10) tick();
    n_chk++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.move_o} !== 16'h0)
      $display("FAIL idle_after_reset: got %h want 0000", {bus.level_o, bus.press_o, bus.release_o, bus.move_o});
    else n_pass++;
  endtask

  task automatic test_clean_press();
    bus.btn_i[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_chk++; if (bus.level_o[0] !== (e >= 6)) $display("FAIL press_level e=%0d: got %b want %b", e, bus.level_o[0], (e >= 6)); else n_pass++;
      n_chk++; if (bus.press_o[0] !== (e == 6)) $display("FAIL press_strobe e=%0d: got %b want %b", e, bus.press_o[0], (e == 6)); else n_pass++;
      n_chk++; if (bus.move_o[0] !== (e == 6)) $display("FAIL press_move e=%0d: got %b want %b", e, bus.move_o[0], (e == 6)); else n_pass++;
    end
    bus.btn_i[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_chk++; if (bus.level_o[0] !== (e < 6)) $display("FAIL rel_level e=%0d: got %b want %b", e, bus.level_o[0], (e < 6)); else n_pass++;
      n_chk++; if (bus.release_o[0] !== (e == 6)) $display("FAIL rel_strobe e=%0d: got %b want %b", e, bus.release_o[0], (e == 6)); else n_pass++;
      n_chk++; if (bus.move_o[0] !== 1'b0) $display("FAIL rel_move e=%0d: got %b want 0", e, bus.move_o[0]); else n_pass++;
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [29:0] pat;
    // index i is the value captured at edge i: pulses 1,2,3 then a 10-cycle hold from 9
    pat = '0;
    pat[0] = 1'b1;
    pat[2] = 1'b1; pat[3] = 1'b1;
    pat[5] = 1'b1; pat[6] = 1'b1; pat[7] = 1'b1;
    for (int i = 9; i < 19; i++) pat[i] = 1'b1;
    for (int e = 0; e < 30; e++) begin
      bus.btn_i[1] = pat[e];
      tick();
      n_chk++; if (bus.level_o[1] !== (e >= 15 && e < 25)) $display("FAIL bounce_level e=%0d: got %b want %b", e, bus.level_o[1], (e >= 15 && e < 25)); else n_pass++;
      n_chk++; if (bus.press_o[1] !== (e == 15)) $display("FAIL bounce_press e=%0d: got %b want %b", e, bus.press_o[1], (e == 15)); else n_pass++;
      n_chk++; if (bus.release_o[1] !== (e == 25)) $display("FAIL bounce_release e=%0d: got %b want %b", e, bus.release_o[1], (e == 25)); else n_pass++;
    end
    settle();
  endtask

  task automatic test_repeat();
    logic exp_mv;
    bus.repeat_en[0] = 1'b1;
    for (int e = 0; e < 36; e++) begin
      bus.btn_i[0] = (e < 20);
      tick();
      exp_mv = (e == 6) || (e == 14) || (e == 17) || (e == 20) || (e == 23);
      n_chk++; if (bus.move_o[0] !== exp_mv) $display("FAIL repeat_move e=%0d: got %b want %b", e, bus.move_o[0], exp_mv); else n_pass++;
      n_chk++; if (bus.release_o[0] !== (e == 26)) $display("FAIL repeat_release e=%0d: got %b want %b", e, bus.release_o[0], (e == 26)); else n_pass++;
    end
    settle();
  endtask

  task automatic test_repeat_disabled();
    bus.repeat_en[0] = 1'b0;
    for (int e = 0; e < 52; e++) begin
      bus.btn_i[0] = (e < 40);
      if (e == 15) bus.repeat_en[0] = 1'b1;
      tick();
      n_chk++; if (bus.move_o[0] !== (e == 6)) $display("FAIL held_move e=%0d: got %b want %b", e, bus.move_o[0], (e == 6)); else n_pass++;
      n_chk++; if (bus.level_o[0] !== (e >= 6 && e < 46)) $display("FAIL held_level e=%0d: got %b want %b", e, bus.level_o[0], (e >= 6 && e < 46)); else n_pass++;
      n_chk++; if (bus.release_o[0] !== (e == 46)) $display("FAIL held_release e=%0d: got %b want %b", e, bus.release_o[0], (e == 46)); else n_pass++;
    end
    settle();
  endtask

  task automatic test_lockout();
    logic exp_mv2;
    bus.repeat_en[2] = 1'b1;
    bus.repeat_en[3] = 1'b1;
    for (int e = 0; e < 41; e++) begin
      bus.btn_i[2] = (e < 27);
      bus.btn_i[3] = (e >= 5 && e < 20);
      tick();
      exp_mv2 = (e == 6) || (e == 26) || (e == 29) || (e == 32);
      n_chk++; if (bus.move_o[2] !== exp_mv2) $display("FAIL lock_move2 e=%0d: got %b want %b", e, bus.move_o[2], exp_mv2); else n_pass++;
      n_chk++; if (bus.move_o[3] !== 1'b0) $display("FAIL lock_move3 e=%0d: got %b want 0", e, bus.move_o[3]); else n_pass++;
      n_chk++; if (bus.press_o[3] !== (e == 11)) $display("FAIL lock_press3 e=%0d: got %b want %b", e, bus.press_o[3], (e == 11)); else n_pass++;
      n_chk++; if (bus.level_o[3] !== (e >= 11 && e < 26)) $display("FAIL lock_level3 e=%0d: got %b want %b", e, bus.level_o[3], (e >= 11 && e < 26)); else n_pass++;
      n_chk++; if (bus.level_o[2] !== (e >= 6 && e < 33)) $display("FAIL lock_level2 e=%0d: got %b want %b", e, bus.level_o[2], (e >= 6 && e < 33)); else n_pass++;
    end
    settle();
  endtask

  task automatic test_reset_mid_repeat();
    bus.repeat_en[0] = 1'b1;
    bus.btn_i[0] = 1'b1;
    for (int e = 0; e < 19; e++) tick();
    n_chk++; if (bus.level_o[0] !== 1'b1) $display("FAIL mid_level_before e=18: got %b want 1", bus.level_o[0]); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.move_o} !== 16'h0)
      $display("FAIL mid_async_clear: got %h want 0000", {bus.level_o, bus.press_o, bus.release_o, bus.move_o});
    else n_pass++;
    repeat (2) tick();
    n_chk++;
    if ({bus.level_o, bus.press_o, bus.release_o, bus.move_o} !== 16'h0)
      $display("FAIL mid_held_in_reset: got %h want 0000", {bus.level_o, bus.press_o, bus.release_o, bus.move_o});
    else n_pass++;
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_chk++; if (bus.level_o[0] !== (e >= 6)) $display("FAIL rerun_level e=%0d: got %b want %b", e, bus.level_o[0], (e >= 6)); else n_pass++;
      n_chk++; if (bus.press_o[0] !== (e == 6)) $display("FAIL rerun_press e=%0d: got %b want %b", e, bus.press_o[0], (e == 6)); else n_pass++;
      n_chk++; if (bus.move_o[0] !== (e == 6)) $display("FAIL rerun_move e=%0d: got %b want %b", e, bus.move_o[0], (e == 6)); else n_pass++;
    end
    settle();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.btn_i     = '0;
    bus.repeat_en = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_repeat_disabled();
    test_lockout();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
